pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Generalises the D/E-style stage register with:
  - configurable payload width;
  - selectable stall semantics (bubble vs hold);
  - an explicit valid bit;
  - a separate non-exception flush;
  - a saturating bubble counter for performance monitoring.
- Instantiated between any two stages (F/D, D/E, E/M, M/W). Carries instruction, PC, delay-slot flag and exception code alongside a generic payload.

---
 rtl/pipe_stage_reg_if.sv | 38 +++
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bundles the controls, upstream fields and registered fields of one
// inter-stage pipeline register.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              req;
  logic              flush;
  logic              stall;
  logic              cnt_clr;
  logic              valid_in;
  logic [31:0]       instr_in;
  logic [31:0]       pc_in;
  logic              bd_in;
  logic [EXC_W-1:0]  exc_in;
  logic [DATA_W-1:0] data_in;

  logic              valid_out;
  logic [31:0]       instr_out;
  logic [31:0]       pc_out;
  logic              bd_out;
  logic [EXC_W-1:0]  exc_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output req, flush, stall, cnt_clr,
    output valid_in, instr_in, pc_in, bd_in, exc_in, data_in,
    input  valid_out, instr_out, pc_out, bd_out, exc_out, data_out, bubble_cnt
  );

  modport slave (
    input  req, flush, stall, cnt_clr,
    input  valid_in, instr_in, pc_in, bd_in, exc_in, data_in,
    output valid_out, instr_out, pc_out, bd_out, exc_out, data_out, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: exception/flush/stall handling with a
// selectable stall policy and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned EXC_W      = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_PC     = 32'h0000_4180,
  parameter int unsigned STALL_MODE = 0,
  parameter int unsigned CNT_W      = 16
) (
  input logic clk,
  input logic reset,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_EXC
  } act_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  act_e              w_act;
  logic              w_bubble;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc;
  logic              r_bd;
  logic [EXC_W-1:0]  r_exc;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  // Priority decode: req > flush > stall > normal load.
  always_comb begin
    w_act = ACT_LOAD;
    if (bus.req) begin
      w_act = ACT_EXC;
    end else if (bus.flush) begin
      w_act = ACT_FLUSH;
    end else if (bus.stall) begin
      w_act = (STALL_MODE != 0) ? ACT_HOLD : ACT_FLUSH;
    end
  end

  assign w_bubble = (w_act == ACT_EXC) || (w_act == ACT_FLUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= RESET_PC;
      r_bd    <= 1'b0;
      r_exc   <= '0;
      r_data  <= '0;
    end else begin
      case (w_act)
        ACT_EXC: begin
          r_valid <= 1'b0;
          r_instr <= '0;
          r_pc    <= EXC_PC;
          r_bd    <= 1'b0;
          r_exc   <= '0;
          r_data  <= '0;
        end
        // Bubble still tracks the upstream PC/delay-slot flag for interrupts.
        ACT_FLUSH: begin
          r_valid <= 1'b0;
          r_instr <= '0;
          r_pc    <= bus.pc_in;
          r_bd    <= bus.bd_in;
          r_exc   <= '0;
          r_data  <= '0;
        end
        ACT_HOLD: begin
        end
        default: begin
          r_valid <= bus.valid_in;
          r_instr <= bus.instr_in;
          r_pc    <= bus.pc_in;
          r_bd    <= bus.bd_in;
          r_exc   <= bus.exc_in;
          r_data  <= bus.data_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_bubble && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign bus.valid_out  = r_valid;
  assign bus.instr_out  = r_instr;
  assign bus.pc_out     = r_pc;
  assign bus.bd_out     = r_bd;
  assign bus.exc_out    = r_exc;
  assign bus.data_out   = r_data;
  assign bus.bubble_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one bubble-mode (4-bit counter) and one hold-mode
// (16-bit counter) instance share stimulus and are checked against a model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;
  localparam int unsigned EW = 5;

  typedef struct {
    logic              v;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic              bd;
    logic [EW-1:0]     exc;
    logic [DW-1:0]     data;
    int unsigned       cnt;
  } exp_t;

  typedef struct {
    bit                req;
    bit                flush;
    bit                stall;
    bit                clr;
    bit                v;
    logic [31:0]       instr;
    logic [31:0]       pc;
    bit                bd;
    logic [EW-1:0]     exc;
    logic [DW-1:0]     data;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .EXC_W(EW), .CNT_W(4))  bus0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .EXC_W(EW), .CNT_W(16)) bus1 ();

  assign bus1.req      = bus0.req;
  assign bus1.flush    = bus0.flush;
  assign bus1.stall    = bus0.stall;
  assign bus1.cnt_clr  = bus0.cnt_clr;
  assign bus1.valid_in = bus0.valid_in;
  assign bus1.instr_in = bus0.instr_in;
  assign bus1.pc_in    = bus0.pc_in;
  assign bus1.bd_in    = bus0.bd_in;
  assign bus1.exc_in   = bus0.exc_in;
  assign bus1.data_in  = bus0.data_in;

  pipe_stage_reg #(
    .DATA_W(DW), .EXC_W(EW), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180),
    .STALL_MODE(0), .CNT_W(4)
  ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  pipe_stage_reg #(
    .DATA_W(DW), .EXC_W(EW), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180),
    .STALL_MODE(1), .CNT_W(16)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t reset_val();
    exp_t r;
    r.v = 1'b0; r.instr = '0; r.pc = 32'h0000_3000; r.bd = 1'b0;
    r.exc = '0; r.data = '0; r.cnt = 0;
    return r;
  endfunction

  // Reference: what the register should hold after one edge with stimulus s.
  function automatic exp_t model_next(input exp_t cur, input stim_t s,
                                      input bit hold_on_stall, input int unsigned cmax);
    exp_t n;
    bit   bub;
    n   = cur;
    bub = 1'b0;
    if (s.req) begin
      n.v = 1'b0; n.instr = '0; n.data = '0; n.exc = '0;
      n.pc = 32'h0000_4180; n.bd = 1'b0; bub = 1'b1;
    end else if (s.flush || (s.stall && !hold_on_stall)) begin
      n.v = 1'b0; n.instr = '0; n.data = '0; n.exc = '0;
      n.pc = s.pc; n.bd = s.bd; bub = 1'b1;
    end else if (!s.stall) begin
      n.v = s.v; n.instr = s.instr; n.pc = s.pc; n.bd = s.bd;
      n.exc = s.exc; n.data = s.data;
    end
    if (s.clr) n.cnt = 0;
    else if (bub && n.cnt < cmax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.req = 0; s.flush = 0; s.stall = 0; s.clr = 0; s.v = 0;
    s.instr = '0; s.pc = '0; s.bd = 0; s.exc = '0; s.data = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.req   = ($urandom_range(15) == 0);
    s.flush = ($urandom_range(7) == 0);
    s.stall = ($urandom_range(3) == 0);
    s.clr   = ($urandom_range(31) == 0);
    s.v     = ($urandom_range(3) != 0);
    s.instr = $urandom;
    s.pc    = $urandom;
    s.bd    = $urandom_range(1) == 1;
    s.exc   = EW'($urandom);
    s.data  = {$urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  task automatic put_inputs(input stim_t s);
    bus0.req = s.req; bus0.flush = s.flush; bus0.stall = s.stall; bus0.cnt_clr = s.clr;
    bus0.valid_in = s.v; bus0.instr_in = s.instr; bus0.pc_in = s.pc;
    bus0.bd_in = s.bd; bus0.exc_in = s.exc; bus0.data_in = s.data;
  endtask

  // Issue one cycle of stimulus and queue what each instance should show.
  task automatic drive(input stim_t s);
    @(negedge clk);
    put_inputs(s);
    m0 = model_next(m0, s, 1'b0, 15);
    m1 = model_next(m1, s, 1'b1, 65535);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic v,
                           input logic [31:0] instr, input logic [31:0] pc, input logic bd,
                           input logic [EW-1:0] exc, input logic [DW-1:0] data,
                           input int unsigned cnt);
    chk({tag, ".valid"}, 128'(v),     128'(e.v));
    chk({tag, ".instr"}, 128'(instr), 128'(e.instr));
    chk({tag, ".pc"},    128'(pc),    128'(e.pc));
    chk({tag, ".bd"},    128'(bd),    128'(e.bd));
    chk({tag, ".exc"},   128'(exc),   128'(e.exc));
    chk({tag, ".data"},  data,        e.data);
    chk({tag, ".cnt"},   128'(cnt),   128'(e.cnt));
  endtask

  task automatic check_reset_state(input string tag);
    exp_t r;
    r = reset_val();
    check_dut({tag, ".d0"}, r, bus0.valid_out, bus0.instr_out, bus0.pc_out, bus0.bd_out,
              bus0.exc_out, bus0.data_out, 32'(bus0.bubble_cnt));
    check_dut({tag, ".d1"}, r, bus1.valid_out, bus1.instr_out, bus1.pc_out, bus1.bd_out,
              bus1.exc_out, bus1.data_out, 32'(bus1.bubble_cnt));
  endtask

  // Monitor: compare each registered result one edge after it was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_dut("sb0", e, bus0.valid_out, bus0.instr_out, bus0.pc_out, bus0.bd_out,
                  bus0.exc_out, bus0.data_out, 32'(bus0.bubble_cnt));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_dut("sb1", e, bus1.valid_out, bus1.instr_out, bus1.pc_out, bus1.bd_out,
                  bus1.exc_out, bus1.data_out, 32'(bus1.bubble_cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    m0 = reset_val();
    m1 = reset_val();
    put_inputs(rand_stim());
    repeat (3) begin
      @(negedge clk);
      put_inputs(rand_stim());
    end
    @(posedge clk);
    #2;
    check_reset_state("rst_hold");
    reset = 1'b1;

    // Normal flow: one-edge latency.
    s = idle();
    s.v = 1; s.instr = 32'h8C41_0004; s.pc = 32'h0000_3004; s.data = {16{8'hA5}};
    drive(s);
    after_edge();
    chk("norm.instr", 128'(bus0.instr_out), 128'(32'h8C41_0004));
    chk("norm.valid", 128'(bus0.valid_out), 128'(1'b1));
    chk("norm.data",  bus0.data_out, {16{8'hA5}});

    // Stall: bubble instance loads bubble, hold instance keeps contents.
    s = idle();
    s.stall = 1; s.v = 1; s.instr = 32'h1234_5678; s.pc = 32'h0000_3008; s.bd = 1;
    drive(s);
    after_edge();
    chk("stall0.pc",    128'(bus0.pc_out),     128'(32'h0000_3008));
    chk("stall0.bd",    128'(bus0.bd_out),     128'(1'b1));
    chk("stall0.instr", 128'(bus0.instr_out),  128'(0));
    chk("stall0.cnt",   128'(bus0.bubble_cnt), 128'(1));
    chk("stall1.instr", 128'(bus1.instr_out),  128'(32'h8C41_0004));
    chk("stall1.pc",    128'(bus1.pc_out),     128'(32'h0000_3004));
    chk("stall1.cnt",   128'(bus1.bubble_cnt), 128'(0));

    // req + flush + stall together: exception vector, one count each.
    s = idle();
    s.req = 1; s.flush = 1; s.stall = 1; s.v = 1; s.pc = 32'h0000_3010; s.bd = 1;
    drive(s);
    after_edge();
    chk("req.pc0",  128'(bus0.pc_out),     128'(32'h0000_4180));
    chk("req.bd0",  128'(bus0.bd_out),     128'(1'b0));
    chk("req.cnt0", 128'(bus0.bubble_cnt), 128'(2));
    chk("req.pc1",  128'(bus1.pc_out),     128'(32'h0000_4180));
    chk("req.cnt1", 128'(bus1.bubble_cnt), 128'(1));

    // Exception code passthrough, then flush clears it.
    s = idle();
    s.v = 1; s.exc = 5'd4; s.pc = 32'h0000_3020;
    drive(s);
    after_edge();
    chk("exc.code", 128'(bus0.exc_out), 128'(5'd4));
    chk("exc.pc",   128'(bus0.pc_out),  128'(32'h0000_3020));
    s.flush = 1;
    drive(s);
    after_edge();
    chk("flush.exc",   128'(bus0.exc_out),   128'(0));
    chk("flush.valid", 128'(bus0.valid_out), 128'(0));

    // Saturation of the 4-bit counter, then clear beating a stall.
    s = idle();
    s.stall = 1; s.pc = 32'h0000_3030;
    repeat (20) drive(s);
    after_edge();
    chk("sat.cnt0", 128'(bus0.bubble_cnt), 128'(15));
    s.clr = 1;
    drive(s);
    after_edge();
    chk("clr.cnt0", 128'(bus0.bubble_cnt), 128'(0));

    // Mid-stream asynchronous reset takes effect before any edge.
    @(negedge clk);
    put_inputs(rand_stim());
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("rst_async");
    m0 = reset_val();
    m1 = reset_val();
    repeat (2) begin
      @(negedge clk);
      put_inputs(rand_stim());
    end
    @(posedge clk);
    #2;
    reset = 1'b1;

    for (int i = 0; i < 400; i++) drive(rand_stim());

    repeat (2) @(posedge clk);
    #3;
    chk("drain.q0", 128'(q0.size()), 128'(0));
    chk("drain.q1", 128'(q1.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
